smi_controller: RTL

Clause-22 MDIO/SMI management master for the Vthernet MAC. It sequences single register read/write transactions to the external GMII PHY over MDC/MDIO, one command at a time, on the Wishbone clock domain. The CSR layer issues commands through a valid/ready request port and collects results from a one-cycle response pulse. The MDIO pad tristate is split into o/oe/i at this boundary and recombined at the top level.

---
 rtl/smi_pkg.sv | 34 +++
 rtl/smi_clk_div.sv | 45 ++++
 rtl/smi_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/smi_pkg.sv
// Shared types and frame constants for the Clause-22 SMI management master.
package smi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_CMD,
        S_TA,
        S_DATA,
        S_DONE
    } smi_state_e;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] TA_WR = 2'b10;

    localparam int unsigned CMD_BITS  = 14;
    localparam int unsigned TA_BITS   = 2;
    localparam int unsigned DATA_BITS = 16;

    // Post-preamble frame, MSB first. Reads fill TA/DATA with ones so the
    // shifter idles high while the PHY owns the line.
    function automatic logic [31:0] build_frame(
        input logic        we,
        input logic [4:0]  phy_addr,
        input logic [4:0]  reg_addr,
        input logic [15:0] wdata
    );
        return {ST, (we ? OP_WR : OP_RD), phy_addr, reg_addr,
                (we ? TA_WR : 2'b11), (we ? wdata : 16'hFFFF)};
    endfunction

endpackage

// File: rtl/smi_clk_div.sv
// MDC generator: free-runs only while enabled, strobes mark MDC edges.
module smi_clk_div #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       mdc_q, mdc_d;
    logic       hit;

    // Divider next state; cleared whenever the controller is idle.
    always_comb begin
        hit   = en && (cnt_q == LAST);
        cnt_d = '0;
        mdc_d = 1'b0;
        if (en) begin
            cnt_d = hit ? '0 : cnt_q + 8'd1;
            mdc_d = hit ? ~mdc_q : mdc_q;
        end
        rise = hit && !mdc_q;
        fall = hit && mdc_q;
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc = mdc_q;

endmodule

// File: rtl/smi_controller.sv
// Clause-22 MDIO master: one read/write register transaction per command.
module smi_controller
    import smi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 10,
    parameter int unsigned PRE_LEN = 32
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        cmd_v,
    output logic        cmd_rdy,
    input  logic        cmd_we,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_v,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        MDC,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam logic [5:0] PRE_LAST  = (PRE_LEN == 0) ? 6'd0 : 6'(PRE_LEN - 1);
    localparam logic [5:0] CMD_LAST  = 6'(CMD_BITS - 1);
    localparam logic [5:0] TA_LAST   = 6'(TA_BITS - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

    smi_state_e  state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] sr_q, sr_d;
    logic [31:0] frame;
    logic [15:0] rd_sh_q, rd_sh_d;
    logic        ta_err_q, ta_err_d;
    logic        we_q, we_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        rsp_v_q, rsp_v_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        mdc_rise, mdc_fall;

    assign busy    = (state_q != S_IDLE);
    assign cmd_rdy = (state_q == S_IDLE);

    smi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk   (wb_clk_i),
        .rst_n (rst_n),
        .en    (busy),
        .mdc   (MDC),
        .rise  (mdc_rise),
        .fall  (mdc_fall)
    );

    // Frame sequencer: launches bits on MDC fall, captures mdio_i on MDC rise.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        rd_sh_d     = rd_sh_q;
        ta_err_d    = ta_err_q;
        we_d        = we_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        rsp_v_d     = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        frame       = build_frame(cmd_we, cmd_phy_addr, cmd_reg_addr, cmd_wdata);

        unique case (state_q)
            S_IDLE: begin
                if (cmd_v) begin
                    we_d      = cmd_we;
                    mdio_oe_d = 1'b1;
                    if (PRE_LEN == 0) begin
                        state_d   = S_CMD;
                        bit_cnt_d = CMD_LAST;
                        mdio_o_d  = frame[31];
                        sr_d      = {frame[30:0], 1'b1};
                    end else begin
                        state_d   = S_PRE;
                        bit_cnt_d = PRE_LAST;
                        mdio_o_d  = 1'b1;
                        sr_d      = frame;
                    end
                end
            end
            S_PRE: begin
                if (mdc_fall) begin
                    if (bit_cnt_q == '0) begin
                        state_d   = S_CMD;
                        bit_cnt_d = CMD_LAST;
                        mdio_o_d  = sr_q[31];
                        sr_d      = {sr_q[30:0], 1'b1};
                    end else begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                    end
                end
            end
            S_CMD: begin
                if (mdc_fall) begin
                    mdio_o_d = sr_q[31];
                    sr_d     = {sr_q[30:0], 1'b1};
                    if (bit_cnt_q == '0) begin
                        state_d   = S_TA;
                        bit_cnt_d = TA_LAST;
                        if (!we_q) mdio_oe_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                    end
                end
            end
            S_TA: begin
                if (mdc_rise && !we_q && bit_cnt_q == '0) ta_err_d = mdio_i;
                if (mdc_fall) begin
                    mdio_o_d = sr_q[31];
                    sr_d     = {sr_q[30:0], 1'b1};
                    if (bit_cnt_q == '0) begin
                        state_d   = S_DATA;
                        bit_cnt_d = DATA_LAST;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                    end
                end
            end
            S_DATA: begin
                if (mdc_rise && !we_q) rd_sh_d = {rd_sh_q[14:0], mdio_i};
                if (mdc_fall) begin
                    if (bit_cnt_q == '0) begin
                        state_d     = S_DONE;
                        rsp_v_d     = 1'b1;
                        mdio_oe_d   = 1'b0;
                        mdio_o_d    = 1'b1;
                        rsp_rdata_d = we_q ? '0 : rd_sh_q;
                        rsp_err_d   = we_q ? 1'b0 : ta_err_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                        mdio_o_d  = sr_q[31];
                        sr_d      = {sr_q[30:0], 1'b1};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer and response registers.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '1;
            rd_sh_q     <= '0;
            ta_err_q    <= 1'b0;
            we_q        <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
            rsp_v_q     <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            rd_sh_q     <= rd_sh_d;
            ta_err_q    <= ta_err_d;
            we_q        <= we_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            rsp_v_q     <= rsp_v_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign rsp_v     = rsp_v_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
